// File: rtl/ex_div.sv
// Iterative 32-bit signed/unsigned restoring divider for the execute stage.
// Produces one quotient bit per cycle and holds the pipeline via stall_req until the result is ready.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_req
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_dividend_mag;
  logic [31:0] w_divisor_mag;
  logic [64:0] w_shifted;
  logic [32:0] w_diff;
  logic [64:0] w_work_next;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // DIV works on magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude.
  assign w_dividend_mag = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
  assign w_divisor_mag  = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;

  // The partial remainder always stays below the divisor, so after the shift it fits in 33 bits
  // and bit 32 of the 33-bit difference is a reliable borrow flag.
  assign w_shifted = {r_work[63:0], 1'b0};
  assign w_diff    = w_shifted[64:32] - {1'b0, r_divisor};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_work_next = w_shifted;
    if (!w_diff[32]) begin
      w_work_next = {w_diff, w_shifted[31:1], 1'b1};
    end
  end

  assign w_quot_fix = r_q_neg ? (32'd0 - r_work[31:0])  : r_work[31:0];
  assign w_rem_fix  = r_r_neg ? (32'd0 - r_work[63:32]) : r_work[63:32];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FREE;
      r_cnt     <= 6'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
    end else if (annul) begin
      r_state <= S_FREE;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_FREE: begin
          if (start) begin
            if (opdata2 == 32'd0) begin
              r_state <= S_BYZERO;
            end else begin
              r_state   <= S_ON;
              r_work    <= {33'd0, w_dividend_mag};
              r_divisor <= w_divisor_mag;
              r_q_neg   <= signed_div & (opdata1[31] ^ opdata2[31]);
              r_r_neg   <= signed_div & opdata1[31];
              r_cnt     <= 6'd0;
            end
          end
        end
        S_BYZERO: begin
          r_result <= 64'd0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          if (r_cnt < 6'd32) begin
            r_work <= w_work_next;
            r_cnt  <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        default: begin
          r_state <= S_FREE;
        end
      endcase
    end
  end

  assign result    = r_result;
  assign ready     = r_ready;
  assign stall_req = start & ~annul & (r_state != S_END);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: stimulus pushes expected {cycle, result}, a monitor pops on ready.
// Stall, annul, back-to-back and reset-mid-operation behaviour are checked with directed vectors.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  typedef struct {
    int          cyc;
    logic [63:0] res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ready(input int at, input logic [63:0] res);
    exp_t e;
    e.cyc = at;
    e.res = res;
    sb.push_back(e);
  endtask

  // Monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {63'd0, ready}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        check("result", result, e.res);
      end
    end
  end

  // One isolated divide; stall_req must be high for cycles 0..lat-1 and low in cycle lat.
  // Operands are scrambled mid-operation to show they are no longer sampled.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int lat);
    int base;
    logic stall_ok;
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    base       = cyc;
    stall_ok   = 1'b1;
    expect_ready(base + lat, exp);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall_req !== (k < lat)) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      if (k == 1) begin
        opdata1    = 32'hDEAD_BEEF;
        opdata2    = 32'd0;
        signed_div = ~s;
      end
    end
    start = 1'b0;
    check({name, "_stall"}, {63'd0, stall_ok}, 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [63:0] held;
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    annul      = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(2);

    run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 34);
    wait_cycles(2);

    // Annul in cycle 10; start stays high so cycle 11 (FREE) launches 9/3.
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    base = cyc;
    wait_cycles(10);
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall_low", {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    #1;
    annul = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
    expect_ready(base + 11 + 34, {32'd0, 32'd3});
    @(negedge clk);
    check("annul_result_hold", result, {32'h0000_0002, 32'h0000_000E});
    wait_cycles(34);
    start = 1'b0;
    wait_cycles(3);

    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 34);
    run_div("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 34);
    run_div("zero_div", 32'h0000_1234, 32'd0, 1'b0, 64'd0, 2);
    wait_cycles(2);

    // Back-to-back: 100/7 then 9/3 with start held high throughout.
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    base = cyc;
    expect_ready(base + 34, {32'h0000_0002, 32'h0000_000E});
    expect_ready(base + 69, {32'd0, 32'd3});
    wait_cycles(34);
    opdata1 = 32'd9; opdata2 = 32'd3;
    @(negedge clk);
    check("b2b_stall_end_low", {63'd0, stall_req}, 64'd0);
    wait_cycles(1);
    @(negedge clk);
    check("b2b_stall_second_high", {63'd0, stall_req}, 64'd1);
    wait_cycles(35);
    start = 1'b0;
    wait_cycles(3);

    // Same start, but reset asserted in cycle 40; released in cycle 41 with start high.
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    base = cyc;
    expect_ready(base + 34, {32'h0000_0002, 32'h0000_000E});
    wait_cycles(34);
    opdata1 = 32'd9; opdata2 = 32'd3;
    wait_cycles(6);
    rst = 1'b0;
    wait_cycles(1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_ready", {63'd0, ready}, 64'd0);
    expect_ready(base + 41 + 34, {32'd0, 32'd3});
    wait_cycles(34);
    start = 1'b0;
    wait_cycles(5);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
